// File: rtl/mips_data_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module : mips_data_ram_responder_if
// Brief  : CPU data-memory bus between the CPU (master) and the data RAM (slave)
// Rev    : 1.0  initial release
// ============================================================================
interface mips_data_ram_responder_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic        access_error;

    modport master (
        output data_address, data_read, data_write, data_writedata,
        input  data_readdata, clk_enable, access_error
    );

    modport slave (
        input  data_address, data_read, data_write, data_writedata,
        output data_readdata, clk_enable, access_error
    );
endinterface
`default_nettype wire

// File: rtl/mips_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module : mips_data_ram_responder
// Brief  : Data RAM with combinational reads, single-cycle writes, wait states
// Rev    : 1.0  initial release
// ============================================================================
module mips_data_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_data_ram_responder_if.slave    bus
);
    localparam int          c_addr_w = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_wait   = 4'(WAIT_STATES);
    localparam logic [30:0] c_depth  = 31'(DEPTH_WORDS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic [31:0]         r_mem [DEPTH_WORDS];
    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_post_reset;

    logic [31:0]         w_offset;
    logic [29:0]         w_word;
    logic [c_addr_w-1:0] w_index;
    logic                w_in_range;
    logic                w_aligned;
    logic                w_access;
    logic                w_valid;
    logic                w_clk_enable;
    logic                w_unused;

    assign w_offset   = bus.data_address - BASE_ADDR;
    assign w_word     = w_offset[31:2];
    assign w_index    = w_word[c_addr_w-1:0];
    assign w_unused   = ^w_offset[1:0];
    assign w_in_range = (bus.data_address >= BASE_ADDR) && ({1'b0, w_word} < c_depth);
    assign w_aligned  = (bus.data_address[1:0] == 2'b00);
    assign w_access   = bus.data_read | bus.data_write;
    assign w_valid    = w_access && w_in_range && w_aligned && !(bus.data_read && bus.data_write);

    assign bus.access_error  = w_access && !w_valid;
    assign bus.data_readdata = (bus.data_read && w_valid) ? r_mem[w_index] : 32'h0;
    assign bus.clk_enable    = w_clk_enable;

    // Reset and the first cycle after it never stall, so the CPU restarts cleanly.
    always_comb begin
        w_clk_enable = 1'b1;
        if (!reset && !r_post_reset) begin
            if (r_state == IDLE) begin
                w_clk_enable = !(w_valid && (c_wait != 4'd0));
            end else if (w_valid) begin
                w_clk_enable = (r_cnt == c_wait);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_post_reset <= 1'b1;
        end else begin
            r_post_reset <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid && (c_wait != 4'd0) && !r_post_reset) begin
                        r_state <= COUNT;
                        r_cnt   <= 4'd1;
                    end
                end
                COUNT: begin
                    // A withdrawn request or the final wait cycle both end the stall.
                    if (!w_valid || (r_cnt == c_wait)) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.data_write && w_valid && w_clk_enable) begin
            r_mem[w_index] <= bus.data_writedata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_data_ram_responder
// Brief  : Randomised scoreboard bench for three responders (0, 1, 2 wait states)
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_data_ram_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_data_ram_responder_if if0 ();
    mips_data_ram_responder_if if1 ();
    mips_data_ram_responder_if if2 ();

    mips_data_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0))
        u_dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
    mips_data_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1))
        u_dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
    mips_data_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2))
        u_dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

    typedef struct {
        int          d;
        int          cyc;
        logic        ce;
        logic [31:0] rdv;
        logic        err;
        int          midx;
        logic [31:0] mval;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cycno = 0;
    int          ws[3] = '{0, 1, 2};

    // Reference model: word array per responder, stall cycles already spent
    // on the current access, and a flag for the cycle right after reset.
    logic [31:0] mm[3][DEPTH];
    int          k[3];
    bit          post[3];
    logic        last_ce[3];

    logic [31:0] ia[3];
    logic [31:0] iwd[3];
    logic        ird[3];
    logic        iwr[3];

    task automatic chk(input string nm, input int d, input int c, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, c, got, want);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            ia[d] = 32'h0; iwd[d] = 32'h0; ird[d] = 1'b0; iwr[d] = 1'b0;
        end
    endtask

    task automatic set_req(input int d, input logic rq, input logic wq, input logic [31:0] a, input logic [31:0] wd);
        idle_all();
        ia[d] = a; iwd[d] = wd; ird[d] = rq; iwr[d] = wq;
    endtask

    task automatic step(input logic r);
        @(posedge clk);
        #1;
        cycno++;
        rst = r;
        if0.data_address = ia[0]; if0.data_read = ird[0]; if0.data_write = iwr[0]; if0.data_writedata = iwd[0];
        if1.data_address = ia[1]; if1.data_read = ird[1]; if1.data_write = iwr[1]; if1.data_writedata = iwd[1];
        if2.data_address = ia[2]; if2.data_read = ird[2]; if2.data_write = iwr[2]; if2.data_writedata = iwd[2];
        for (int d = 0; d < 3; d++) begin
            exp_t        e;
            int unsigned wi;
            bit          inr, acc, val;
            wi  = (ia[d] - BASE) >> 2;
            inr = (ia[d] >= BASE) && (wi < DEPTH);
            acc = ird[d] || iwr[d];
            val = acc && inr && (ia[d] % 4 == 0) && !(ird[d] && iwr[d]);
            e.d    = d;
            e.cyc  = cycno;
            e.err  = acc && !val;
            e.rdv  = 32'h0;
            if (ird[d] && val) e.rdv = mm[d][wi];
            e.midx = inr ? int'(wi) : int'($urandom_range(0, DEPTH - 1));
            e.mval = mm[d][e.midx];
            if (r) begin
                e.ce = 1'b1; k[d] = 0; post[d] = 1'b1;
            end else if (post[d] || !val) begin
                e.ce = 1'b1; k[d] = 0; post[d] = 1'b0;
            end else if (k[d] == ws[d]) begin
                e.ce = 1'b1; k[d] = 0;
            end else begin
                e.ce = 1'b0; k[d]++;
            end
            if (!r && e.ce && val && iwr[d]) mm[d][wi] = iwd[d];
            last_ce[d] = e.ce;
            sbq.push_back(e);
        end
    endtask

    // Hold a request until the model says the CPU is released.
    task automatic txn(input int d, input logic rq, input logic wq, input logic [31:0] a, input logic [31:0] wd);
        set_req(d, rq, wq, a, wd);
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (last_ce[d]) break;
        end
        idle_all();
    endtask

    task automatic peek(input int d, input int mi, output logic ce, output logic [31:0] rdv,
                        output logic err, output logic [31:0] mv);
        case (d)
            0: begin ce = if0.clk_enable; rdv = if0.data_readdata; err = if0.access_error; mv = u_dut0.r_mem[mi]; end
            1: begin ce = if1.clk_enable; rdv = if1.data_readdata; err = if1.access_error; mv = u_dut1.r_mem[mi]; end
            default: begin ce = if2.clk_enable; rdv = if2.data_readdata; err = if2.access_error; mv = u_dut2.r_mem[mi]; end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                exp_t        e;
                logic        ce, err;
                logic [31:0] rdv, mv;
                e = sbq.pop_front();
                peek(e.d, e.midx, ce, rdv, err, mv);
                chk("clk_enable", e.d, e.cyc, {31'h0, ce}, {31'h0, e.ce});
                chk("data_readdata", e.d, e.cyc, rdv, e.rdv);
                chk("access_error", e.d, e.cyc, {31'h0, err}, {31'h0, e.err});
                chk("mem_word", e.d, e.cyc, mv, e.mval);
            end
        end
    end

    initial begin
        logic [31:0] v;
        idle_all();
        for (int d = 0; d < 3; d++) begin
            k[d] = 0; post[d] = 1'b0; last_ce[d] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom; u_dut0.r_mem[i] = v; mm[0][i] = v;
            v = $urandom; u_dut1.r_mem[i] = v; mm[1][i] = v;
            v = $urandom; u_dut2.r_mem[i] = v; mm[2][i] = v;
        end
        u_dut2.r_mem[3] = 32'hDEAD_BEEF; mm[2][3] = 32'hDEAD_BEEF;

        step(1'b1);
        step(1'b1);
        step(1'b0);

        txn(2, 1'b1, 1'b0, 32'h0C, 32'h0);
        txn(2, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
        txn(2, 1'b1, 1'b0, 32'h10, 32'h0);
        txn(2, 1'b1, 1'b0, 32'h0E, 32'h0);
        txn(2, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0);
        txn(2, 1'b0, 1'b1, 32'h0E, 32'hCAFE_F00D);
        txn(2, 1'b1, 1'b1, 32'h08, 32'h5555_AAAA);

        // Reset during the first stall cycle of a write.
        set_req(2, 1'b0, 1'b1, 32'h20, 32'hA5A5_0F0F);
        step(1'b0);
        step(1'b1);
        idle_all();
        step(1'b0);
        txn(2, 1'b0, 1'b1, 32'h24, 32'h0BAD_CAFE);
        txn(2, 1'b1, 1'b0, 32'h20, 32'h0);

        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 1'b0, 32'h00, 32'h0);
            txn(d, 1'b1, 1'b0, 32'h04, 32'h0);
            txn(d, 1'b1, 1'b0, 32'h08, 32'h0);
        end

        for (int n = 0; n < 400; n++) begin
            int          d, kind, r;
            logic [31:0] a, wd;
            d    = $urandom_range(0, 2);
            kind = $urandom_range(0, 11);
            a    = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            wd   = $urandom;
            case (kind)
                0, 1, 2: set_req(d, 1'b1, 1'b0, a, wd);
                3, 4, 5: set_req(d, 1'b0, 1'b1, a, wd);
                6:  set_req(d, $urandom_range(0, 1) == 1, 1'b0, a + 32'($urandom_range(1, 3)), wd);
                7:  set_req(d, 1'b1, 1'b0, BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15) * 4), wd);
                8:  set_req(d, 1'b0, 1'b1, a | 32'h8000_0000, wd);
                9:  set_req(d, 1'b1, 1'b1, a, wd);
                default: idle_all();
            endcase
            if (kind == 11 && $urandom_range(0, 3) == 0) begin
                step(1'b1);
                idle_all();
                step(1'b0);
                continue;
            end
            for (int i = 0; i < 20; i++) begin
                step(1'b0);
                if (last_ce[d]) break;
                r = $urandom_range(0, 99);
                if (r < 8) begin
                    idle_all();
                    step(1'b0);
                    break;
                end else if (r < 18) begin
                    ia[d] = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
                end else if (r < 21) begin
                    step(1'b1);
                    idle_all();
                    step(1'b0);
                    break;
                end
            end
            idle_all();
        end

        step(1'b0);
        step(1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, cycno, 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
